// File: rtl/param_counter_if.sv
// Control and status bundle for param_counter: the master drives the controls,
// and the counter (slave) returns count, tc and ovf.
interface param_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic             sat;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    modport master (
        output clr, load, load_val, en, up, sat,
        input  count, tc, ovf
    );

    modport slave (
        input  clr, load, load_val, en, up, sat,
        output count, tc, ovf
    );
endinterface

// File: rtl/param_counter.sv
// Up/down counter with programmable ceiling, wrap or saturate at the bounds,
// a one-cycle terminal-count pulse and a sticky overflow flag.
module param_counter #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic            clk,
    input  logic            rst,
    param_counter_if.slave  bus
);

    logic             run_q;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             at_bound_c;
    logic [WIDTH-1:0] load_clamp_c;
    logic [WIDTH-1:0] step_c;
    logic [WIDTH-1:0] wrap_c;

    // Next-state: clr beats load beats en; updates held off until run_q arms.
    always_comb begin
        count_d      = count_q;
        tc_d         = 1'b0;
        ovf_d        = ovf_q;
        at_bound_c   = bus.up ? (count_q == MAX_VAL) : (count_q == '0);
        load_clamp_c = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        step_c       = bus.up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        wrap_c       = bus.up ? '0 : MAX_VAL;

        if (run_q) begin
            if (bus.clr) begin
                count_d = '0;
                ovf_d   = 1'b0;
            end else if (bus.load) begin
                count_d = load_clamp_c;
            end else if (bus.en) begin
                if (at_bound_c) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    if (!bus.sat) begin
                        count_d = wrap_c;
                    end
                end else begin
                    count_d = step_c;
                end
            end
        end
    end

    // run_q registers the release of rst so the first edge after it only arms the counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q   <= 1'b0;
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: table of vectors on a WIDTH=3/MAX_VAL=5 instance,
// plus hand sequences for reset timing, the 8-bit default and the MAX_VAL=1 case.
module tb_param_counter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    param_counter_if #(.WIDTH(3)) bus_a ();
    param_counter_if #(.WIDTH(8)) bus_b ();
    param_counter_if #(.WIDTH(2)) bus_c ();

    param_counter #(.WIDTH(3), .MAX_VAL(3'd5)) u_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    param_counter #(.WIDTH(8))                 u_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
    param_counter #(.WIDTH(2), .MAX_VAL(2'd1)) u_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       load;
        logic [2:0] lv;
        logic       en;
        logic       up;
        logic       sat;
        int         e_cnt;
        logic       e_tc;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[26];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic clr, input logic load, input logic [2:0] lv,
                           input logic en, input logic up, input logic sat);
        bus_a.clr = clr; bus_a.load = load; bus_a.load_val = lv;
        bus_a.en = en;   bus_a.up = up;     bus_a.sat = sat;
    endtask

    task automatic chk_a(input string tag, input int c, input logic t, input logic o);
        chk({tag, " count"}, int'(bus_a.count), c);
        chk({tag, " tc"},    int'(bus_a.tc),    int'(t));
        chk({tag, " ovf"},   int'(bus_a.ovf),   int'(o));
    endtask

    task automatic chk_b(input string tag, input int c, input logic t, input logic o);
        chk({tag, " count"}, int'(bus_b.count), c);
        chk({tag, " tc"},    int'(bus_b.tc),    int'(t));
        chk({tag, " ovf"},   int'(bus_b.ovf),   int'(o));
    endtask

    task automatic chk_c(input string tag, input int c, input logic t, input logic o);
        chk({tag, " count"}, int'(bus_c.count), c);
        chk({tag, " tc"},    int'(bus_c.tc),    int'(t));
        chk({tag, " ovf"},   int'(bus_c.ovf),   int'(o));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;

        //            clr load lv  en up sat  cnt tc ovf
        vecs[0]  = '{1'b0,1'b0,3'd0,1'b1,1'b1,1'b0, 0,1'b0,1'b0}; // arming edge: hold
        vecs[1]  = '{1'b0,1'b0,3'd0,1'b1,1'b1,1'b0, 1,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,3'd0,1'b1,1'b1,1'b0, 2,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b0,3'd0,1'b1,1'b1,1'b0, 3,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b0,3'd0,1'b1,1'b1,1'b0, 4,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b0,3'd0,1'b1,1'b1,1'b0, 5,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,3'd0,1'b1,1'b1,1'b0, 0,1'b1,1'b1};
        vecs[7]  = '{1'b0,1'b0,3'd0,1'b1,1'b1,1'b0, 1,1'b0,1'b1};
        vecs[8]  = '{1'b0,1'b1,3'd4,1'b0,1'b1,1'b0, 4,1'b0,1'b1};
        vecs[9]  = '{1'b0,1'b1,3'd2,1'b1,1'b1,1'b0, 2,1'b0,1'b1};
        vecs[10] = '{1'b0,1'b0,3'd0,1'b1,1'b1,1'b0, 3,1'b0,1'b1};
        vecs[11] = '{1'b0,1'b1,3'd7,1'b0,1'b1,1'b0, 5,1'b0,1'b1};
        vecs[12] = '{1'b1,1'b1,3'd7,1'b0,1'b1,1'b0, 0,1'b0,1'b0};
        vecs[13] = '{1'b0,1'b0,3'd0,1'b1,1'b0,1'b1, 0,1'b1,1'b1};
        vecs[14] = '{1'b0,1'b0,3'd0,1'b1,1'b0,1'b1, 0,1'b1,1'b1};
        vecs[15] = '{1'b0,1'b0,3'd0,1'b1,1'b0,1'b1, 0,1'b1,1'b1};
        vecs[16] = '{1'b0,1'b0,3'd0,1'b0,1'b0,1'b1, 0,1'b0,1'b1};
        vecs[17] = '{1'b0,1'b0,3'd0,1'b0,1'b1,1'b0, 0,1'b0,1'b1};
        vecs[18] = '{1'b0,1'b0,3'd0,1'b1,1'b0,1'b0, 5,1'b1,1'b1};
        vecs[19] = '{1'b0,1'b0,3'd0,1'b1,1'b0,1'b0, 4,1'b0,1'b1};
        vecs[20] = '{1'b0,1'b1,3'd5,1'b0,1'b0,1'b0, 5,1'b0,1'b1};
        vecs[21] = '{1'b0,1'b0,3'd0,1'b1,1'b1,1'b1, 5,1'b1,1'b1};
        vecs[22] = '{1'b0,1'b0,3'd0,1'b1,1'b0,1'b1, 4,1'b0,1'b1};
        vecs[23] = '{1'b0,1'b0,3'd0,1'b1,1'b1,1'b0, 5,1'b0,1'b1};
        vecs[24] = '{1'b1,1'b0,3'd0,1'b1,1'b1,1'b0, 0,1'b0,1'b0};
        vecs[25] = '{1'b0,1'b1,3'd3,1'b1,1'b0,1'b0, 3,1'b0,1'b0};

        rst = 1'b0;
        drive_a(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        bus_b.clr = 1'b0; bus_b.load = 1'b0; bus_b.load_val = 8'd0;
        bus_b.en  = 1'b0; bus_b.up   = 1'b0; bus_b.sat      = 1'b0;
        bus_c.clr = 1'b0; bus_c.load = 1'b0; bus_c.load_val = 2'd0;
        bus_c.en  = 1'b0; bus_c.up   = 1'b0; bus_c.sat      = 1'b0;

        step();
        step();
        chk_a("reset", 0, 1'b0, 1'b0);

        rst = 1'b1;
        for (int i = 0; i < 26; i++) begin
            drive_a(vecs[i].clr, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].up, vecs[i].sat);
            step();
            chk_a($sformatf("row%0d", i), vecs[i].e_cnt, vecs[i].e_tc, vecs[i].e_ovf);
        end

        // Async reset between edges while count=3, then two-edge restart.
        drive_a(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 chk_a("async_rst", 0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        drive_a(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        step();
        chk_a("restart_e1", 0, 1'b0, 1'b0);
        step();
        chk_a("restart_e2", 1, 1'b0, 1'b0);
        step();
        chk_a("restart_e3", 2, 1'b0, 1'b0);

        // Reset held across a pending boundary event: no update, no tc afterwards.
        drive_a(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
        step();
        chk_a("preload5", 5, 1'b0, 1'b0);
        drive_a(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b0;
        step();
        chk_a("rst_over_event", 0, 1'b0, 1'b0);
        rst = 1'b1;
        drive_a(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk_a("after_rst_event", 0, 1'b0, 1'b0);

        // 8-bit default: down from 0 wraps to 255, then up wraps back.
        bus_b.en = 1'b1; bus_b.up = 1'b0; bus_b.sat = 1'b0;
        step();
        chk_b("w8_down_wrap", 255, 1'b1, 1'b1);
        bus_b.up = 1'b1;
        step();
        chk_b("w8_up_wrap", 0, 1'b1, 1'b1);
        bus_b.en = 1'b0;
        step();
        chk_b("w8_idle", 0, 1'b0, 1'b1);

        // MAX_VAL=1 toggles in wrap mode, each bound crossing is an event.
        bus_c.en = 1'b1; bus_c.up = 1'b1; bus_c.sat = 1'b0;
        step();
        chk_c("m1_up0", 1, 1'b0, 1'b0);
        step();
        chk_c("m1_up1", 0, 1'b1, 1'b1);
        step();
        chk_c("m1_up2", 1, 1'b0, 1'b1);
        bus_c.up = 1'b0;
        step();
        chk_c("m1_dn0", 0, 1'b0, 1'b1);
        step();
        chk_c("m1_dn1", 1, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
